// File: rtl/seg_pkg.sv
// Shared constants for the scanned 7-segment display: segment codes, glyphs,
// converter FSM encoding and decode helpers. Optional macro: SIGNED_DISPLAY_EN.
package seg_pkg;

  localparam int unsigned VAL_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 3;

  // Active-low segment codes, bit order gfedcba
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_A   = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_L   = 7'h47;
  localparam logic [SEG_W-1:0] GLYPH_S   = 7'h12;
  localparam logic [SEG_W-1:0] GLYPH_B   = 7'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  function automatic logic [SEG_W-1:0] digit_seg(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [SEG_W-1:0] op_glyph(input logic [OP_W-1:0] op);
    logic [SEG_W-1:0] s;
    case (op)
      2'b00:   s = GLYPH_A;
      2'b01:   s = GLYPH_L;
      2'b10:   s = GLYPH_S;
      default: s = GLYPH_B;
    endcase
    return s;
  endfunction

  // Shift-add-3 correction applied to one BCD nibble before each shift
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter with UPDATE/BUSY handshake.
// With SIGNED_DISPLAY_EN the input is two's complement and a sign flag is kept.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_i,
  input  logic [VAL_W-1:0] value_i,
  input  logic [OP_W-1:0]  op_i,
  output logic             busy_o,
  output logic [BCD_W-1:0] bcd_o,
`ifdef SIGNED_DISPLAY_EN
  output logic             neg_o,
`endif
  output logic [OP_W-1:0]  op_o
);

  conv_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] scratch_q, scratch_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [OP_W-1:0]  op_sh_q, op_sh_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [BCD_W-1:0] adj_c;
  logic [VAL_W-1:0] mag_c;
`ifdef SIGNED_DISPLAY_EN
  logic             neg_sh_q, neg_sh_d;
  logic             neg_q, neg_d;

  assign mag_c = value_i[VAL_W-1] ? VAL_W'(-value_i) : value_i;
`else
  assign mag_c = value_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (update_i) state_d = ST_CONV;
      ST_CONV: if (cnt_q == CNT_W'(7)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign adj_c = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    op_sh_d   = op_sh_q;
    op_d      = op_q;
`ifdef SIGNED_DISPLAY_EN
    neg_sh_d  = neg_sh_q;
    neg_d     = neg_q;
`endif
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (update_i) begin
          shift_d   = mag_c;
          op_sh_d   = op_i;
          scratch_d = '0;
          cnt_d     = '0;
`ifdef SIGNED_DISPLAY_EN
          neg_sh_d  = value_i[VAL_W-1];
`endif
        end
      end
      ST_CONV: begin
        {scratch_d, shift_d} = {adj_c, shift_q} << 1;
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
      ST_DONE: begin
        bcd_d = scratch_q;
        op_d  = op_sh_q;
`ifdef SIGNED_DISPLAY_EN
        neg_d = neg_sh_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      op_sh_q   <= '0;
      op_q      <= '0;
`ifdef SIGNED_DISPLAY_EN
      neg_sh_q  <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      op_sh_q   <= op_sh_d;
      op_q      <= op_d;
`ifdef SIGNED_DISPLAY_EN
      neg_sh_q  <= neg_sh_d;
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign bcd_o  = bcd_q;
  assign op_o   = op_q;
`ifdef SIGNED_DISPLAY_EN
  assign neg_o  = neg_q;
`endif

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver: decimal value plus opcode glyph.
// Optional macro SIGNED_DISPLAY_EN shows a minus on the leftmost digit for negatives.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [VAL_W-1:0] VALUE_IN,
  input  logic [OP_W-1:0]  OP_IN,
  input  logic             UPDATE,
  output logic             BUSY,
  output logic [BCD_W-1:0] BCD,
  output logic [AN_W-1:0]  AN,
  output logic [SEG_W-1:0] SEG
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [BCD_W-1:0] disp_bcd;
  logic [OP_W-1:0]  disp_op;
  logic [SEG_W-1:0] left_seg_c;
  logic             wrap_c;

`ifdef SIGNED_DISPLAY_EN
  logic             disp_neg;
`endif

  bin2bcd_seq u_conv (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .update_i (UPDATE),
    .value_i  (VALUE_IN),
    .op_i     (OP_IN),
    .busy_o   (BUSY),
    .bcd_o    (disp_bcd),
`ifdef SIGNED_DISPLAY_EN
    .neg_o    (disp_neg),
`endif
    .op_o     (disp_op)
  );

`ifdef SIGNED_DISPLAY_EN
  assign left_seg_c = disp_neg ? SEG_MINUS : op_glyph(disp_op);
`else
  assign left_seg_c = op_glyph(disp_op);
`endif

  assign wrap_c = (presc_q == PRE_W'(SCAN_DIV - 1));

  // Digit selection with leading-zero blanking on hundreds and tens
  always_comb begin
    presc_d = wrap_c ? '0 : PRE_W'(presc_q + PRE_W'(1));
    idx_d   = wrap_c ? 2'(idx_q + 2'd1) : idx_q;
    an_d    = ~(AN_W'(1) << idx_q);
    seg_d   = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = digit_seg(disp_bcd[3:0]);
      2'd1: seg_d = (disp_bcd[11:4] == 8'h00) ? SEG_BLANK : digit_seg(disp_bcd[7:4]);
      2'd2: seg_d = (disp_bcd[11:8] == 4'h0) ? SEG_BLANK : digit_seg(disp_bcd[11:8]);
      default: seg_d = left_seg_c;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign BCD = disp_bcd;

endmodule
